// File: rtl/svga_pkg.sv
// svga_pkg: mode encodings and geometry helpers shared by the SVGA pixel path
package svga_pkg;
  typedef enum logic [1:0] {BPP_1 = 2'b00, BPP_2 = 2'b01, BPP_4 = 2'b10, BPP_1_ALT = 2'b11} bpp_e;
  typedef enum logic [1:0] {REP_1 = 2'b00, REP_2 = 2'b01, REP_4 = 2'b10, REP_8 = 2'b11} rep_e;
  function automatic int unsigned bpp_bits(bpp_e bpp);
    return (bpp == BPP_4) ? 4 : (bpp == BPP_2) ? 2 : 1;
  endfunction
  function automatic int unsigned ppw(bpp_e bpp, logic nibble, int unsigned data_w);
    return (nibble ? data_w / 2 : data_w) / bpp_bits(bpp);
  endfunction
  function automatic int unsigned rep_len(rep_e rep);
    return 32'd1 << rep;
  endfunction
endpackage

// File: rtl/pixel_hold_buffer.sv
// pixel_hold_buffer: single-word hold stage between the VRAM fetcher and the shifter
module pixel_hold_buffer #(
  parameter int DATA_W = 8
) (
  input  logic              pixel_clock,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              take_i,
  input  logic              data_valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] hold_o,
  output logic              full_o,
  output logic              data_req_o,
  output logic              overrun_o
);
  logic [DATA_W-1:0] hold_q, hold_d;
  logic full_q, full_d, req_q, overrun_q, overrun_d;
  // a full hold only empties when the shifter takes it; a delivery into a full hold is lost
  always_comb begin
    full_d = clear_i ? 1'b0 : full_q ? !take_i : data_valid_i;
    hold_d = (!clear_i && !full_q && data_valid_i) ? data_i : hold_q;
    overrun_d = !clear_i && (overrun_q || (full_q && data_valid_i));
  end
  // hold state, request and sticky overrun registers
  always_ff @(posedge pixel_clock or posedge reset)
    if (reset) begin
      hold_q <= '0;
      full_q <= 1'b0;
      req_q <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      full_q <= full_d;
      req_q <= !full_d;
      overrun_q <= overrun_d;
    end
  assign hold_o = hold_q;
  assign full_o = full_q;
  assign data_req_o = req_q;
  assign overrun_o = overrun_q;
endmodule

// File: rtl/pixel_serializer.sv
// pixel_serializer: runtime-depth VRAM word to pixel serialiser with repeat, fine scroll and error flags
module pixel_serializer #(
  parameter int DATA_W = 8,
  parameter int MAX_BPP = 4
) (
  input  logic               pixel_clock,
  input  logic               reset,
  input  logic               line_start_i,
  input  logic               active_i,
  input  logic [1:0]         bpp_sel_i,
  input  logic [1:0]         rep_sel_i,
  input  logic               nibble_mode_i,
  input  logic [2:0]         fine_scroll_i,
  input  logic [DATA_W-1:0]  data_in_i,
  input  logic               data_valid_i,
  output logic               data_req_o,
  output logic [MAX_BPP-1:0] pixel_out_o,
  output logic               pixel_valid_o,
  output logic               underrun_o,
  output logic               overrun_o
);
  import svga_pkg::*;
  localparam int PCW = $clog2(DATA_W);
  bpp_e bpp_q, bpp_d;
  rep_e rep_q, rep_d;
  logic nib_q, nib_d;
  logic [2:0] skip_q, skip_d, rep_cnt_q, rep_cnt_d;
  logic [PCW-1:0] pix_q, pix_d;
  logic [DATA_W-1:0] shift_q, shift_d, shifted, hold_w;
  logic shift_full_q, shift_full_d, hold_full, load, prime, slot_end;
  logic [MAX_BPP-1:0] pixel_q, pixel_d, top;
  logic valid_q, valid_d, underrun_q, underrun_d;
  int unsigned new_ppw;
  pixel_hold_buffer #(.DATA_W(DATA_W)) u_hold (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .clear_i     (line_start_i),
    .take_i      (load),
    .data_valid_i(data_valid_i),
    .data_i      (data_in_i),
    .hold_o      (hold_w),
    .full_o      (hold_full),
    .data_req_o  (data_req_o),
    .overrun_o   (overrun_o)
  );
  // counters only advance on slots that were actually shown, so an active gap never eats a repeat
  always_comb begin
    new_ppw = ppw(bpp_e'(bpp_sel_i), nibble_mode_i, DATA_W);
    shifted = shift_q << bpp_bits(bpp_q);
    slot_end = valid_q && rep_cnt_q == 3'd0;
    load = hold_full && (!shift_full_q || (slot_end && pix_q == '0));
    prime = shift_full_q && skip_q != 3'd0;
    bpp_d = bpp_q;
    rep_d = rep_q;
    nib_d = nib_q;
    skip_d = skip_q;
    shift_d = shift_q;
    shift_full_d = shift_full_q;
    pix_d = pix_q;
    rep_cnt_d = rep_cnt_q;
    if (line_start_i) begin
      bpp_d = bpp_e'(bpp_sel_i);
      rep_d = rep_e'(rep_sel_i);
      nib_d = nibble_mode_i;
      skip_d = (32'(fine_scroll_i) > new_ppw - 1) ? 3'(new_ppw - 1) : fine_scroll_i;
      shift_full_d = 1'b0;
      pix_d = '0;
      rep_cnt_d = 3'd0;
    end else if (load) begin
      shift_d = nib_q ? {hold_w[DATA_W/2-1:0], {(DATA_W/2){1'b0}}} : hold_w;
      shift_full_d = 1'b1;
      pix_d = PCW'(ppw(bpp_q, nib_q, DATA_W) - 1);
      rep_cnt_d = 3'(rep_len(rep_q) - 1);
    end else if (prime) begin
      shift_d = shifted;
      pix_d = pix_q - PCW'(1);
      skip_d = skip_q - 3'd1;
    end else if (valid_q) begin
      if (rep_cnt_q != 3'd0)
        rep_cnt_d = rep_cnt_q - 3'd1;
      else if (pix_q != '0) begin
        shift_d = shifted;
        pix_d = pix_q - PCW'(1);
        rep_cnt_d = 3'(rep_len(rep_q) - 1);
      end else
        shift_full_d = 1'b0;
    end
    top = (bpp_q == BPP_4) ? MAX_BPP'(shift_d[DATA_W-1 -: 4]) :
          (bpp_q == BPP_2) ? MAX_BPP'(shift_d[DATA_W-1 -: 2]) : MAX_BPP'(shift_d[DATA_W-1]);
    valid_d = active_i && !line_start_i && shift_full_d && skip_d == 3'd0;
    pixel_d = valid_d ? top : '0;
    underrun_d = !line_start_i && (underrun_q || (active_i && !shift_full_q && !hold_full));
  end
  // mode latch, shifter, counters and registered outputs
  always_ff @(posedge pixel_clock or posedge reset)
    if (reset) begin
      bpp_q <= BPP_1;
      rep_q <= REP_1;
      nib_q <= 1'b0;
      skip_q <= 3'd0;
      shift_q <= '0;
      shift_full_q <= 1'b0;
      pix_q <= '0;
      rep_cnt_q <= 3'd0;
      pixel_q <= '0;
      valid_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      bpp_q <= bpp_d;
      rep_q <= rep_d;
      nib_q <= nib_d;
      skip_q <= skip_d;
      shift_q <= shift_d;
      shift_full_q <= shift_full_d;
      pix_q <= pix_d;
      rep_cnt_q <= rep_cnt_d;
      pixel_q <= pixel_d;
      valid_q <= valid_d;
      underrun_q <= underrun_d;
    end
  assign pixel_out_o = pixel_q;
  assign pixel_valid_o = valid_q;
  assign underrun_o = underrun_q;
endmodule

// File: doc/pixel_serializer.md
Name: pixel_serializer

Overview:
Parametrised successor to the fixed-mode graphics pixel shifters. One shift datapath serialises VRAM bytes at a runtime-selected depth: 1, 2 or 4 bits per pixel, full word or low-nibble mode. Each pixel is repeated 1, 2, 4 or 8 clocks. The block adds:
- a double-buffered hold register with a request/valid handshake to the VRAM fetcher
- per-line fine horizontal scroll
- underrun and overrun detection

It sits between the VRAM fetch sequencer and the palette/colour latch in the SVGA path.

Parameters:
DATA_W, 8, fetched word width; must be a multiple of 8.
MAX_BPP, 4, width of pixel_out; supported depths are 1, 2 and 4.

Ports:
pixel_clock  in  1  pixel clock; all state changes on rising edge.
reset  in  1  asynchronous, active-high.
line_start  in  1  one-cycle pulse at the start of each line's fetch window; restarts the block.
active  in  1  display-enable; high during visible pixels.
bpp_sel  in  2  00=1bpp, 01=2bpp, 10=4bpp; 11 is treated as 1bpp.
rep_sel  in  2  pixel repeat of 1, 2, 4 or 8 clocks.
nibble_mode  in  1  use only data_in[DATA_W/2-1:0].
fine_scroll  in  3  source pixels discarded from the first word of the line.
data_in  in  DATA_W  fetched pixel word.
data_valid  in  1  data_in is valid this cycle.
data_req  out  1  hold register empty; fetcher may deliver.
pixel_out  out  MAX_BPP  current pixel, zero-extended in the LSBs.
pixel_valid  out  1  pixel_out is meaningful this cycle.
underrun  out  1  sticky; cleared at line_start.
overrun  out  1  sticky; cleared at line_start.

Behaviour:
- Reset (asynchronous, any time, including mid-line):
  - outputs: pixel_out=0, pixel_valid=0, underrun=0, overrun=0, data_req=1
  - internal: hold empty, shift empty, all counters 0, latched mode = 1bpp / rep1 / full word.
- line_start:
  - synchronously latches bpp_sel, rep_sel, nibble_mode and fine_scroll.
  - empties hold and shift, clears both flags and loads skip_cnt with the clamped fine_scroll.
  - mode inputs are ignored at all other times; a mid-line change takes effect at the next line_start.
  - line_start takes priority over every other event in the same cycle; a data_valid in that cycle is dropped.
- Pixels per word (ppw) = DATA_W/bpp, halved in nibble mode. Example: DATA_W=8, 2bpp → 4; nibble 1bpp → 4.
  - fine_scroll is clamped to ppw-1.
- Hold register:
  - data_valid while hold is empty: captures data_in; hold becomes full next edge.
  - data_valid while hold is full: data dropped, overrun set.
  - data_req is registered and equals !hold_full of the next state.
- Shift register:
  - loads from hold when shift is empty, or on the final repeat slot of the last pixel while active.
  - the load is seamless: no bubble cycle.
  - loading sets pix_cnt=ppw-1 and rep_cnt=rep-1. The same edge frees hold, so data_req rises the next cycle.
  - in nibble mode the low half is placed in the MSBs of the shift register.
- Priming: while skip_cnt>0 and the shift register holds data, shift one source pixel per clock regardless of active.
  - skip_cnt and pix_cnt decrement; pixel_valid=0 during priming.
- Output while active and the shift register holds data:
  - pixel_out = top bpp bits of the shift register; MSB pixel first.
  - pixel_valid=1; the pixel holds for rep clocks, then the register shifts by bpp.
  - all outputs are registered. The first pixel appears 2 edges after data_valid (hold, then shift/output).
- active low: the shift register and counters freeze; pixel_out=0, pixel_valid=0.
- Underrun: active high, shift exhausted and hold empty.
  - underrun set; pixel_out=0, pixel_valid=0.
  - output resumes from pixel 0 of the next delivered word.
- Both flags are sticky until line_start or reset.

Decomposition:
- Shared package `svga_pkg`:
  - BPP_1/2/4 and REP_1/2/4/8 encodings
  - function ppw(bpp, nibble)
  - function rep_len(rep_sel)
- One sub-module, `pixel_hold_buffer`: the hold register plus data_req/overrun logic. The shift, repeat and skip control stays in the top level.

Test Plan:
- 1bpp, rep2, DATA_W=8:
  - stimulus: line_start, data 8'hA5 with active high, then 8'h3C delivered on data_req.
  - response: pixel_out 1,1,0,0,1,1,0,0,0,0,1,1,0,0,1,1 then 0,0,0,0,1,1,1,1,… with no gap; pixel_valid continuous.
- 2bpp, rep1:
  - stimulus: data 8'b11_10_01_00.
  - response: pixel_out 3,2,1,0; data_req rises the cycle after the shift load.
- nibble 4bpp vs nibble 1bpp:
  - stimulus: data 8'h7E in nibble 4bpp, then in nibble 1bpp.
  - response: 4bpp outputs the single pixel 4'hE; 1bpp outputs 1,1,1,0.
- fine scroll, 1bpp:
  - stimulus: fine_scroll=3, data 8'b10110010, active raised after priming.
  - response: first valid pixels are 1,0,0,1,0; pixel_valid=0 during the 3 priming clocks.
- underrun then overrun:
  - stimulus: withhold data while active, then send two data_valid pulses without data_req.
  - response: underrun=1 and pixel_out=0 during the gap; overrun=1 from the second pulse; both clear on line_start.
- reset mid-line:
  - stimulus: assert reset asynchronously between clock edges during output.
  - response: pixel_valid=0, pixel_out=0, data_req=1 immediately; no pixel emitted until line_start and new data.
